// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the multiplexed RTC address/data bus: one full
// address+data strobe sequence per grant, T_PHASE cycles per bus phase.
module rtc_bus_arbiter #(
  parameter int T_PHASE = 9
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [23:0] addr_bus,
  input  logic [23:0] wdata_bus,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        ChipSelect,
  output logic        Read,
  output logic        Write,
  output logic        AoD,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in
);

  localparam int            CW       = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(T_PHASE - 1);

  // Encoding is sequential so the phase walk is a plain increment.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A_SET = 3'd1;
  localparam logic [2:0] S_A_STB = 3'd2;
  localparam logic [2:0] S_A_HLD = 3'd3;
  localparam logic [2:0] S_D_SET = 3'd4;
  localparam logic [2:0] S_D_STB = 3'd5;
  localparam logic [2:0] S_D_HLD = 3'd6;
  localparam logic [2:0] S_RECOV = 3'd7;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;
  logic [1:0]    owner;
  txn_t          txn;

  logic          win_vld;
  logic [1:0]    win;
  logic [2:0]    cand;
  logic          phase_end;

  // Search from rr_ptr upward; iterating backwards lets the nearest hit win.
  always_comb begin
    win_vld = 1'b0;
    win     = rr_ptr;
    cand    = '0;
    for (int i = 2; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req[cand[1:0]]) begin
        win_vld = 1'b1;
        win     = cand[1:0];
      end
    end
  end

  assign phase_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
      owner  <= '0;
      txn    <= '0;
      done   <= '0;
      rdata  <= '0;
    end else begin
      done <= '0;
      if (state == S_IDLE) begin
        cnt <= '0;
        if (win_vld) begin
          state      <= S_A_SET;
          owner      <= win;
          rr_ptr     <= (win == 2'd2) ? 2'd0 : win + 2'd1;
          txn.we     <= we[win];
          txn.addr   <= addr_bus[{win, 3'b000} +: 8];
          txn.wdata  <= wdata_bus[{win, 3'b000} +: 8];
        end
      end else if (phase_end) begin
        cnt <= '0;
        if (state == S_D_STB && !txn.we) rdata <= ad_in;
        if (state == S_RECOV) begin
          state <= S_IDLE;
          done  <= 3'b001 << owner;
        end else begin
          state <= state + 3'd1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pin strobes decode straight from state so an async reset releases the bus at once.
  always_comb begin
    busy       = (state != S_IDLE);
    gnt        = busy ? (3'b001 << owner) : 3'b000;
    ChipSelect = 1'b1;
    Read       = 1'b1;
    Write      = 1'b1;
    AoD        = 1'b0;
    ad_oe      = 1'b0;
    ad_out     = '0;
    case (state)
      S_A_SET, S_A_HLD: begin
        ChipSelect = 1'b0;
        ad_oe      = 1'b1;
        ad_out     = txn.addr;
      end
      S_A_STB: begin
        ChipSelect = 1'b0;
        ad_oe      = 1'b1;
        ad_out     = txn.addr;
        Write      = 1'b0;
      end
      S_D_SET, S_D_HLD: begin
        ChipSelect = 1'b0;
        AoD        = 1'b1;
        ad_oe      = txn.we;
        ad_out     = txn.we ? txn.wdata : 8'h00;
      end
      S_D_STB: begin
        ChipSelect = 1'b0;
        AoD        = 1'b1;
        ad_oe      = txn.we;
        ad_out     = txn.we ? txn.wdata : 8'h00;
        Write      = !txn.we;
        Read       = txn.we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model that derives pin values from the cycle offset in a grant.
module tb_rtc_bus_arbiter;
  localparam int TP = 2;

  logic        clk = 1'b0;
  logic        Reset;
  logic [2:0]  req, we;
  logic [23:0] addr_bus, wdata_bus;
  logic [2:0]  gnt, done;
  logic [7:0]  rdata, ad_out, ad_in;
  logic        busy, ChipSelect, Read, Write, AoD, ad_oe;

  rtc_bus_arbiter #(.T_PHASE(TP)) dut (
    .clk(clk), .Reset(Reset), .req(req), .we(we), .addr_bus(addr_bus),
    .wdata_bus(wdata_bus), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .ChipSelect(ChipSelect), .Read(Read), .Write(Write), .AoD(AoD),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Transaction model: m_k is the cycle offset inside the current grant.
  bit         m_act;
  int         m_k, m_owner, m_rr;
  bit         m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic [2:0] m_done;
  int         glog[$];
  logic [2:0] prev_gnt;
  int         n_rd_lo, n_wr_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_k = 0; m_rr = 0; m_rdata = 8'h00; m_done = 3'b000;
  endtask

  task automatic model_edge();
    int c;
    m_done = 3'b000;
    if (!Reset) begin
      model_reset();
      return;
    end
    if (m_act) begin
      if (m_k == 5*TP-1 && !m_we) m_rdata = ad_in;
      if (m_k == 7*TP-1) begin
        m_act  = 0;
        m_done = 3'b001 << m_owner;
      end else begin
        m_k++;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        c = (m_rr + i) % 3;
        if (req[c]) begin
          m_act = 1; m_k = 0; m_owner = c; m_we = we[c];
          m_addr = addr_bus[8*c +: 8]; m_wdata = wdata_bus[8*c +: 8];
          m_rr = (c + 1) % 3;
          break;
        end
      end
    end
  endtask

  task automatic check_outs();
    int p;
    logic cs_e, rd_e, wr_e, aod_e, oe_e;
    logic [7:0] out_e;
    logic [2:0] gnt_e;
    p = m_k / TP;
    cs_e = 1; rd_e = 1; wr_e = 1; aod_e = 0; oe_e = 0; out_e = 8'h00; gnt_e = 3'b000;
    if (m_act) begin
      gnt_e = 3'b001 << m_owner;
      cs_e  = (p == 6);
      wr_e  = !(p == 1 || (p == 4 && m_we));
      rd_e  = !(p == 4 && !m_we);
      aod_e = (p >= 3 && p <= 5);
      oe_e  = (p <= 2) || (p <= 5 && m_we);
      out_e = (p <= 2) ? m_addr : m_wdata;
    end
    chk("gnt", gnt, gnt_e);
    chk("busy", busy, m_act);
    chk("done", done, m_done);
    chk("cs", ChipSelect, cs_e);
    chk("rd", Read, rd_e);
    chk("wr", Write, wr_e);
    chk("aod", AoD, aod_e);
    chk("ad_oe", ad_oe, oe_e);
    if (oe_e) chk("ad_out", ad_out, out_e);
    chk("rdata", rdata, m_rdata);
    chk("no_rd_wr", !(!Read && !Write), 1'b1);
    chk("rd_oe", !(!Read && ad_oe), 1'b1);
    chk("gnt_1h", $onehot0(gnt), 1'b1);
    if (!Read)  n_rd_lo++;
    if (!Write) n_wr_lo++;
    if (gnt != 3'b000 && prev_gnt == 3'b000) glog.push_back(gnt[1] ? 1 : (gnt[2] ? 2 : 0));
    prev_gnt = gnt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic wait_done(input int k, input int max, output int n);
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (m_done[k]) begin
        n = i;
        req[k] = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    req   = 3'b000;
    model_reset();
    repeat (3) step();
    chk("rst_adout", ad_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    Reset = 1'b1;
  endtask

  int n, gs;

  initial begin
    Reset = 1'b0; req = 3'b000; we = 3'b000; addr_bus = '0; wdata_bus = '0;
    ad_in = 8'h00; prev_gnt = 3'b000; n_rd_lo = 0; n_wr_lo = 0;
    model_reset();
    do_reset();

    // Single read from requester 2
    ad_in = 8'h45; addr_bus[23:16] = 8'h21; we[2] = 1'b0; req[2] = 1'b1;
    n_rd_lo = 0; n_wr_lo = 0;
    wait_done(2, 40, n);
    chk("rd_latency", n, 15);
    chk("rd_read_lo", n_rd_lo, TP);
    chk("rd_write_lo", n_wr_lo, TP);
    chk("rd_rdata", rdata, 8'h45);

    // Single write from requester 0; rdata must hold
    addr_bus[7:0] = 8'h42; wdata_bus[7:0] = 8'h17; we[0] = 1'b1; req[0] = 1'b1;
    ad_in = 8'h9c;
    n_rd_lo = 0; n_wr_lo = 0;
    wait_done(0, 40, n);
    chk("wr_latency", n, 15);
    chk("wr_write_lo", n_wr_lo, 2*TP);
    chk("wr_read_lo", n_rd_lo, 0);
    chk("wr_rdata", rdata, 8'h45);

    // All three requesting from reset: strict rotation
    do_reset();
    glog.delete();
    we = 3'($urandom); addr_bus = 24'($urandom); wdata_bus = 24'($urandom);
    req = 3'b111;
    repeat (60) step();
    req = 3'b000;
    repeat (4) step();
    chk("rr_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("rr_g0", glog[0], 0);
      chk("rr_g1", glog[1], 1);
      chk("rr_g2", glog[2], 2);
      chk("rr_g3", glog[3], 0);
    end

    // Reset during data strobe of a write
    do_reset();
    we[0] = 1'b1; addr_bus = 24'($urandom); wdata_bus = 24'($urandom);
    req = 3'b011;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_act && m_k / TP == 4) break;
    end
    chk("mid_reach", (m_act && m_k / TP == 4 && m_owner == 0), 1'b1);
    req[0] = 1'b0;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("mid_cs", ChipSelect, 1'b1);
    chk("mid_wr", Write, 1'b1);
    chk("mid_oe", ad_oe, 1'b0);
    chk("mid_gnt", gnt, 3'b000);
    repeat (2) step();
    Reset = 1'b1;
    glog.delete();
    wait_done(1, 40, n);
    chk("mid_latency", n, 15);
    chk("mid_gcount", glog.size(), 1);
    if (glog.size() > 0) chk("mid_first", glog[0], 1);

    // Requester 1 drops req during address hold
    we[1] = 1'($urandom); req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_act && m_k / TP == 2) break;
    end
    req[1] = 1'b0;
    wait_done(1, 40, n);
    chk("drop_done", (n <= 40), 1'b1);
    gs = glog.size();
    repeat (10) step();
    chk("drop_noregrant", glog.size(), gs);

    // Random traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      ad_in = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        if (m_done[k]) begin
          req[k] = 1'b0;
        end else if (!req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[k] = 1'b1;
            we[k] = 1'($urandom);
            addr_bus[8*k +: 8]  = 8'($urandom);
            wdata_bus[8*k +: 8] = 8'($urandom);
          end
        end else if (m_act && m_owner == k) begin
          if ($urandom_range(0, 7) == 0) begin
            we[k] = 1'($urandom);
            addr_bus[8*k +: 8]  = 8'($urandom);
            wdata_bus[8*k +: 8] = 8'($urandom);
          end
          if ($urandom_range(0, 31) == 0) req[k] = 1'b0;
        end
      end
    end
    req = 3'b000;
    repeat (20) step();
    chk("drain_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
